// File: rtl/eth_filter_pkg.sv
// Shared types and constants for the RX destination-address filter.
package eth_filter_pkg;

  localparam int          HDR_BYTES      = 6;
  localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_REPLAY,
    ST_PASS,
    ST_DROP
  } filt_state_t;

  function automatic logic addr_match(
    input logic [47:0] addr,
    input logic [47:0] station,
    input logic        promisc,
    input logic        bcast,
    input logic        mcast
  );
    return promisc | (addr == station) | (bcast & (addr == ETH_BCAST_ADDR)) | (mcast & addr[40]);
  endfunction

endpackage

// File: rtl/eth_stat_counter.sv
// Wrap-around event counter; clear wins over a same-cycle increment.
module eth_stat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_inc,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eth_rx_addr_filter.sv
// Destination-MAC filter: buffers the address, decides accept/drop, replays
// the header and passes the remainder of accepted frames through.
module eth_rx_addr_filter
  import eth_filter_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst_n,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          mac_addr,
  input  logic                 promisc_en,
  input  logic                 bcast_en,
  input  logic                 mcast_en,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] accept_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] runt_cnt
);

  filt_state_t r_state;
  filt_state_t w_state_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic        r_run;
  logic [7:0]  r_hdr_buf [HDR_BYTES];

  logic        w_hdr_fire;
  logic        w_idx_last;
  logic [47:0] w_addr;
  logic        w_match;
  logic        w_buf_we;
  logic        w_acc_inc;
  logic        w_drop_inc;
  logic        w_runt_inc;

  // r_run keeps tready low until the first clock after reset release.
  assign w_hdr_fire = s_axis_tvalid & r_run;
  assign w_idx_last = (r_idx == 3'(HDR_BYTES - 1));
  assign w_addr     = {r_hdr_buf[0], r_hdr_buf[1], r_hdr_buf[2],
                       r_hdr_buf[3], r_hdr_buf[4], s_axis_tdata};
  assign w_match    = addr_match(w_addr, mac_addr, promisc_en, bcast_en, mcast_en);

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_state <= ST_HDR;
      r_idx   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge logic_clk) begin
    if (w_buf_we) begin
      r_hdr_buf[r_idx] <= s_axis_tdata;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_buf_we      = 1'b0;
    w_acc_inc     = 1'b0;
    w_drop_inc    = 1'b0;
    w_runt_inc    = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (r_state)
      ST_HDR: begin
        s_axis_tready = r_run;
        if (w_hdr_fire) begin
          w_buf_we = ~s_axis_tlast;
          if (s_axis_tlast) begin
            w_runt_inc = 1'b1;
            w_idx_next = '0;
          end else if (w_idx_last) begin
            w_idx_next = '0;
            if (w_match) begin
              w_state_next = ST_REPLAY;
            end else begin
              w_state_next = ST_DROP;
              w_drop_inc   = 1'b1;
            end
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      ST_REPLAY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_hdr_buf[r_idx];
        if (m_axis_tready) begin
          if (w_idx_last) begin
            w_idx_next   = '0;
            w_state_next = ST_PASS;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      ST_PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid & m_axis_tready & s_axis_tlast) begin
          w_acc_inc    = 1'b1;
          w_state_next = ST_HDR;
        end
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid & s_axis_tlast) begin
          w_state_next = ST_HDR;
        end
      end
      default: begin
        w_state_next = ST_HDR;
        w_idx_next   = '0;
      end
    endcase
  end

  eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_accept_cnt (
    .i_clk   (logic_clk),
    .i_rst_n (logic_rst_n),
    .i_inc   (w_acc_inc),
    .i_clear (cnt_clear),
    .o_count (accept_cnt)
  );

  eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .i_clk   (logic_clk),
    .i_rst_n (logic_rst_n),
    .i_inc   (w_drop_inc),
    .i_clear (cnt_clear),
    .o_count (drop_cnt)
  );

  eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_runt_cnt (
    .i_clk   (logic_clk),
    .i_rst_n (logic_rst_n),
    .i_inc   (w_runt_inc),
    .i_clear (cnt_clear),
    .o_count (runt_cnt)
  );

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Bench for eth_rx_addr_filter: directed vector table, hand sequences and
// randomized frames checked against a frame-level reference model.
module tb_eth_rx_addr_filter;

  localparam int CW = 32;
  localparam logic [47:0] OWN_MAC = 48'h02_00_00_00_00_01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          m_tuser;
  logic [47:0]   mac = OWN_MAC;
  logic          promisc = 1'b0;
  logic          bcast = 1'b0;
  logic          mcast = 1'b0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] drp_cnt;
  logic [CW-1:0] rnt_cnt;

  always #5 clk = ~clk;

  eth_rx_addr_filter #(.CNT_WIDTH(CW)) dut (
    .logic_clk     (clk),
    .logic_rst_n   (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .mac_addr      (mac),
    .promisc_en    (promisc),
    .bcast_en      (bcast),
    .mcast_en      (mcast),
    .cnt_clear     (cnt_clear),
    .accept_cnt    (acc_cnt),
    .drop_cnt      (drp_cnt),
    .runt_cnt      (rnt_cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct {
    int          len;
    logic [47:0] dst;
    bit          pr;
    bit          bc;
    bit          mc;
    bit          tu;
    int          e_acc;
    int          e_drop;
    int          e_runt;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  beat_t out_q[$];
  beat_t exp_q[$];
  logic [7:0] fr_q[$];
  int    exp_acc = 0, exp_drop = 0, exp_runt = 0;
  bit    saw_mvalid = 0;
  int    first_out_cyc = -1;
  int    b5_cyc = -1;
  int    stall_cnt = 0;
  int    stab_err = 0;
  bit    rand_ready = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: sampled mid-cycle, a transfer seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid) begin
        saw_mvalid = 1;
        if (first_out_cyc < 0) first_out_cyc = cyc;
      end
      if (prev_stall && (!m_tvalid || prev_beat != {m_tdata, m_tlast, m_tuser})) stab_err++;
      prev_stall = m_tvalid & ~m_tready;
      prev_beat  = {m_tdata, m_tlast, m_tuser};
      if (m_tvalid && m_tready) out_q.push_back({m_tdata, m_tlast, m_tuser});
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic build_frame(input logic [47:0] dst, input int len);
    fr_q.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) fr_q.push_back(dst[47-8*i -: 8]);
      else fr_q.push_back(8'($urandom));
    end
  endtask

  // abort_after >= 0 stops after that byte index without sending tlast.
  task automatic send_frame(input logic tu, input int abort_after, input bit clr_last);
    int t;
    for (int i = 0; i < fr_q.size(); i++) begin
      @(posedge clk);
      #1;
      s_tvalid  = 1'b1;
      s_tdata   = fr_q[i];
      s_tlast   = (i == fr_q.size() - 1);
      s_tuser   = (i == fr_q.size() - 1) ? tu : 1'b0;
      cnt_clear = clr_last && (i == fr_q.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (s_tready) break;
        stall_cnt++;
        t++;
        if (t > 500) begin
          $display("FAIL s_tready_timeout: got stalled %0d cycles required accept", t);
          $fatal(1, "input handshake timeout");
        end
      end
      if (i == 5) b5_cyc = cyc;
      if (i == abort_after) begin
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tuser   = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic push_expected(input logic tu);
    for (int i = 0; i < fr_q.size(); i++) begin
      beat_t b;
      b.d = fr_q[i];
      b.l = (i == fr_q.size() - 1);
      b.u = (i == fr_q.size() - 1) ? tu : 1'b0;
      exp_q.push_back(b);
    end
  endtask

  // Frame-level reference: classify a whole frame from the filtering rules.
  task automatic model_frame(input logic tu);
    bit own, bc, hit;
    if (fr_q.size() <= 6) begin
      exp_runt++;
    end else begin
      own = 1;
      bc  = 1;
      for (int i = 0; i < 6; i++) begin
        if (fr_q[i] != mac[47-8*i -: 8]) own = 0;
        if (fr_q[i] != 8'hFF) bc = 0;
      end
      hit = promisc || own || (bcast && bc) || (mcast && fr_q[0][0]);
      if (hit) begin
        push_expected(tu);
        exp_acc++;
      end else begin
        exp_drop++;
      end
    end
  endtask

  task automatic settle_and_compare(input string tag);
    int t = 0;
    int bad = 0;
    idle();
    while (out_q.size() < exp_q.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_out_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      if (out_q[i] != exp_q[i]) bad++;
    check({tag, "_out_data"}, bad, 0);
    check({tag, "_accept_cnt"}, acc_cnt, exp_acc);
    check({tag, "_drop_cnt"}, drp_cnt, exp_drop);
    check({tag, "_runt_cnt"}, rnt_cnt, exp_runt);
    out_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{64, OWN_MAC,             0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{64, 48'h020000000002,    0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{64, 48'h020000000002,    1, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{30, 48'hFFFFFFFFFFFF,    0, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{30, 48'hFFFFFFFFFFFF,    0, 1, 0, 0, 1, 0, 0};
    vecs[5]  = '{20, 48'h01005E000001,    0, 0, 1, 0, 1, 0, 0};
    vecs[6]  = '{20, 48'h01005E000001,    0, 0, 0, 0, 0, 1, 0};
    vecs[7]  = '{4,  OWN_MAC,             0, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{6,  OWN_MAC,             0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{7,  OWN_MAC,             0, 0, 0, 0, 1, 0, 0};
    vecs[10] = '{25, OWN_MAC,             0, 0, 0, 1, 1, 0, 0};
    vecs[11] = '{16, 48'hFFFFFFFFFFFF,    0, 0, 1, 0, 1, 0, 0};
    vecs[12] = '{6,  48'h0A0B0C0D0E0F,    1, 0, 0, 0, 0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast_tuser", {m_tlast, m_tuser}, 0);
    check("rst_counters", acc_cnt | drp_cnt | rnt_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", s_tready, 1);

    // Directed table, m_tready held high.
    foreach (vecs[v]) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      promisc = vecs[v].pr;
      bcast   = vecs[v].bc;
      mcast   = vecs[v].mc;
      build_frame(vecs[v].dst, vecs[v].len);
      saw_mvalid    = 0;
      first_out_cyc = -1;
      stall_cnt     = 0;
      send_frame(vecs[v].tu, -1, 0);
      if (vecs[v].e_acc != 0) push_expected(vecs[v].tu);
      exp_acc  += vecs[v].e_acc;
      exp_drop += vecs[v].e_drop;
      exp_runt += vecs[v].e_runt;
      settle_and_compare(tag);
      check({tag, "_mvalid_seen"}, saw_mvalid, vecs[v].e_acc);
      check({tag, "_in_stalls"}, stall_cnt, (vecs[v].e_acc != 0) ? 6 : 0);
      if (vecs[v].e_acc != 0)
        check({tag, "_latency"}, first_out_cyc - b5_cyc, 1);
    end

    // Three back-to-back frames with a random sink, middle one flagged bad.
    promisc = 0; bcast = 0; mcast = 0;
    rand_ready = 1;
    build_frame(OWN_MAC, 40); model_frame(1'b0); send_frame(1'b0, -1, 0);
    build_frame(OWN_MAC, 50); model_frame(1'b1); send_frame(1'b1, -1, 0);
    build_frame(OWN_MAC, 35); model_frame(1'b0); send_frame(1'b0, -1, 0);
    settle_and_compare("b2b3");

    // Randomized frames, configs and addresses against the reference model.
    for (int f = 0; f < 40; f++) begin
      logic [47:0] dst;
      logic tu;
      case ($urandom_range(0, 4))
        0: dst = OWN_MAC;
        1: dst = 48'hFFFFFFFFFFFF;
        2: dst = {24'h01005E, 24'($urandom)};
        3: dst = {8'($urandom) & 8'hFE, 40'({$urandom, $urandom})};
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      promisc = ($urandom_range(0, 3) == 0);
      bcast   = 1'($urandom);
      mcast   = 1'($urandom);
      tu      = 1'($urandom);
      build_frame(dst, $urandom_range(1, 48));
      model_frame(tu);
      send_frame(tu, -1, 0);
    end
    settle_and_compare("rand");
    rand_ready = 0;

    // Reset while passing byte 20 of an accepted frame.
    promisc = 0; bcast = 0; mcast = 0;
    build_frame(OWN_MAC, 64);
    send_frame(1'b0, 20, 0);
    rst_n = 1'b0;
    #2;
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_counters", acc_cnt | drp_cnt | rnt_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
    exp_q.delete();
    exp_acc = 0; exp_drop = 0; exp_runt = 0;
    @(posedge clk);
    #1;
    check("midrst_post_s_tready", s_tready, 1);
    build_frame(OWN_MAC, 12); model_frame(1'b0); send_frame(1'b0, -1, 0);
    build_frame(48'h020000000009, 12); model_frame(1'b0); send_frame(1'b0, -1, 0);
    build_frame(OWN_MAC, 3); model_frame(1'b0); send_frame(1'b0, -1, 0);
    settle_and_compare("after_rst");

    // Counter clear coinciding with an accept tlast wins.
    build_frame(OWN_MAC, 15);
    push_expected(1'b0);
    send_frame(1'b0, -1, 1);
    exp_acc = 0; exp_drop = 0; exp_runt = 0;
    settle_and_compare("clr_on_last");
    build_frame(OWN_MAC, 9); model_frame(1'b0); send_frame(1'b0, -1, 0);
    settle_and_compare("after_clr");

    check("hold_stable", stab_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
